ms_sram_like_stage: RTL and testbench

Memory-access (MEM) pipeline stage for the five-stage core, sitting between the EX and WB stage registers. It is the successor to the single-cycle-SRAM MEM stage and targets an SRAM-like data bus, where responses return a variable number of cycles after the request (`data_ok`). It holds the instruction until its response arrives and buffers read data while WB stalls. It also performs full load alignment and extension (W/H/HU/B/BU) and, on pipeline flush, discards responses to requests that are still outstanding.

---
 rtl/ms_sram_like_stage.sv | 168 ++++++++++++++++
 tb/tb_ms_sram_like_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ms_sram_like_stage.sv
// MEM pipeline stage for an SRAM-like data bus: holds each instruction until its
// response arrives, buffers read data across WB stalls, aligns loads, and drops stale responses.
module ms_sram_like_stage #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned RF_ADDR_W = 5,
  parameter int unsigned CNT_W     = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   es_to_ms_valid,
  output logic                   ms_allowin,
  input  logic [PC_W-1:0]        es_pc,
  input  logic [RF_ADDR_W+33:0]  es_rf_collect,
  input  logic                   es_mem_req,
  input  logic [2:0]             es_ld_op,
  input  logic                   flush,
  input  logic                   data_sram_data_ok,
  input  logic [31:0]            data_sram_rdata,
  input  logic                   ws_allowin,
  output logic                   ms_to_ws_valid,
  output logic [PC_W-1:0]        ms_pc,
  output logic [RF_ADDR_W+32:0]  ms_rf_collect,
  output logic                   ms_ld_block
);

  localparam int unsigned SumW = CNT_W + 2;

  logic                 ms_valid_q, ms_valid_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic                 res_from_mem_q, res_from_mem_d;
  logic                 rf_we_q, rf_we_d;
  logic [RF_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [31:0]          alu_result_q, alu_result_d;
  logic                 mem_req_q, mem_req_d;
  logic [2:0]           ld_op_q, ld_op_d;
  logic                 buf_valid_q, buf_valid_d;
  logic [31:0]          buf_data_q, buf_data_d;
  logic [CNT_W-1:0]     discard_cnt_q, discard_cnt_d;

  logic                 es_res_from_mem, es_rf_we;
  logic [RF_ADDR_W-1:0] es_rf_waddr;
  logic [31:0]          es_alu_result;

  logic        cnt_zero, resp_mine, ms_ready_go, accept, leave, flush_own;
  logic [1:0]  cnt_inc;
  logic        cnt_dec;
  logic [SumW-1:0] cnt_sum;
  logic [31:0] ld_src, ld_data, rf_wdata;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;

  assign {es_res_from_mem, es_rf_we, es_rf_waddr, es_alu_result} = es_rf_collect;

  // A response belongs to this instruction only once every discarded one has drained.
  assign cnt_zero    = (discard_cnt_q == '0);
  assign resp_mine   = data_sram_data_ok & cnt_zero;
  assign ms_ready_go = ~mem_req_q | buf_valid_q | resp_mine;
  assign ms_allowin  = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign accept      = es_to_ms_valid & ms_allowin & ~flush;
  assign leave       = ms_valid_q & ms_ready_go & ws_allowin;

  always_comb begin
    ms_valid_d     = ms_valid_q;
    pc_d           = pc_q;
    res_from_mem_d = res_from_mem_q;
    rf_we_d        = rf_we_q;
    rf_waddr_d     = rf_waddr_q;
    alu_result_d   = alu_result_q;
    mem_req_d      = mem_req_q;
    ld_op_d        = ld_op_q;
    if (flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end
    if (accept) begin
      pc_d           = es_pc;
      res_from_mem_d = es_res_from_mem;
      rf_we_d        = es_rf_we;
      rf_waddr_d     = es_rf_waddr;
      alu_result_d   = es_alu_result;
      mem_req_d      = es_mem_req;
      ld_op_d        = es_ld_op;
    end
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (flush || leave) begin
      buf_valid_d = 1'b0;
    end else if (ms_valid_q && mem_req_q && !buf_valid_q && resp_mine && !ws_allowin) begin
      buf_valid_d = 1'b1;
      buf_data_d  = data_sram_rdata;
    end
  end

  // On flush, count requests whose responses are still in flight; a response landing
  // in the flush cycle itself has already been consumed and is not counted.
  always_comb begin
    flush_own = ms_valid_q & mem_req_q & ~buf_valid_q & ~resp_mine;
    cnt_inc   = 2'b00;
    if (flush) begin
      cnt_inc = {1'b0, flush_own} + {1'b0, es_to_ms_valid & es_mem_req};
    end
    cnt_dec       = data_sram_data_ok & ~cnt_zero;
    cnt_sum       = SumW'(discard_cnt_q) + SumW'(cnt_inc) - SumW'(cnt_dec);
    discard_cnt_d = cnt_sum[CNT_W-1:0];
  end

  always_comb begin
    ld_src  = buf_valid_q ? buf_data_q : data_sram_rdata;
    ld_half = alu_result_q[1] ? ld_src[31:16] : ld_src[15:0];
    case (alu_result_q[1:0])
      2'b00:   ld_byte = ld_src[7:0];
      2'b01:   ld_byte = ld_src[15:8];
      2'b10:   ld_byte = ld_src[23:16];
      default: ld_byte = ld_src[31:24];
    endcase
    case (ld_op_q)
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = {16'h0000, ld_half};
      3'b011:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h000000, ld_byte};
      default: ld_data = ld_src;
    endcase
    rf_wdata = res_from_mem_q ? ld_data : alu_result_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid_q     <= 1'b0;
      pc_q           <= '0;
      res_from_mem_q <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      alu_result_q   <= '0;
      mem_req_q      <= 1'b0;
      ld_op_q        <= '0;
      buf_valid_q    <= 1'b0;
      buf_data_q     <= '0;
      discard_cnt_q  <= '0;
    end else begin
      ms_valid_q     <= ms_valid_d;
      pc_q           <= pc_d;
      res_from_mem_q <= res_from_mem_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      alu_result_q   <= alu_result_d;
      mem_req_q      <= mem_req_d;
      ld_op_q        <= ld_op_d;
      buf_valid_q    <= buf_valid_d;
      buf_data_q     <= buf_data_d;
      discard_cnt_q  <= discard_cnt_d;
    end
  end

  // Too many outstanding discards means the bus has more requests in flight than we track.
  discard_cnt_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    cnt_sum[SumW-1:CNT_W] == '0);

  // A flushed instruction is never handed to WB, even if it happens to be ready.
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go & ~flush;
  assign ms_pc          = pc_q;
  assign ms_rf_collect  = {rf_we_q & ms_valid_q, rf_waddr_q, rf_wdata};
  assign ms_ld_block    = ms_valid_q & res_from_mem_q & ~ms_ready_go;

endmodule

// File: tb/tb_ms_sram_like_stage.sv
// Bench for ms_sram_like_stage: table of load/ALU vectors with hand-computed results,
// plus sequences for WB stall buffering, flush discards and mid-wait reset.
module tb_ms_sram_like_stage;
  localparam int unsigned PC_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned CNT_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  resetn, es_to_ms_valid, ms_allowin, es_mem_req, flush;
  logic [PC_W-1:0]       es_pc, ms_pc;
  logic [RF_ADDR_W+33:0] es_rf_collect;
  logic [2:0]            es_ld_op;
  logic                  data_sram_data_ok, ws_allowin, ms_to_ws_valid, ms_ld_block;
  logic [31:0]           data_sram_rdata;
  logic [RF_ADDR_W+32:0] ms_rf_collect;

  ms_sram_like_stage #(.PC_W(PC_W), .RF_ADDR_W(RF_ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_rf_collect(es_rf_collect), .es_mem_req(es_mem_req),
    .es_ld_op(es_ld_op), .flush(flush), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_rf_collect(ms_rf_collect),
    .ms_ld_block(ms_ld_block)
  );

  typedef struct {
    logic [2:0]  ld_op;
    logic [31:0] alu;
    logic        res;
    logic        we;
    logic        mreq;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [PC_W-1:0]       pc;
    logic [RF_ADDR_W+32:0] coll;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (ms_to_ws_valid && ws_allowin) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_wb: got pc=%h coll=%h expected no WB output", ms_pc,
                 ms_rf_collect);
      end else begin
        e = sb.pop_front();
        if ({ms_pc, ms_rf_collect} !== {e.pc, e.coll}) begin
          failures++;
          $display("FAIL wb_output: got pc=%h coll=%h expected pc=%h coll=%h", ms_pc,
                   ms_rf_collect, e.pc, e.coll);
        end
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input vec_t v, input logic [PC_W-1:0] pc,
                       input logic [RF_ADDR_W-1:0] wa, input bit push);
    exp_t e;
    int   n;
    n = 0;
    es_to_ms_valid = 1'b1;
    es_pc          = pc;
    es_rf_collect  = {v.res, v.we, wa, v.alu};
    es_mem_req     = v.mreq;
    es_ld_op       = v.ld_op;
    sample();
    while (!ms_allowin && n < 20) begin
      adv();
      sample();
      n++;
    end
    chk("issue_allowin", 64'(ms_allowin), 64'd1);
    if (push) begin
      e.pc   = pc;
      e.coll = {v.we, wa, v.exp};
      sb.push_back(e);
    end
    adv();
    es_to_ms_valid = 1'b0;
    es_mem_req     = 1'b0;
  endtask

  task automatic respond(input vec_t v);
    for (int i = 0; i < v.delay; i++) begin
      sample();
      chk("wait_ld_block", 64'(ms_ld_block), 64'(v.res));
      chk("wait_no_out", 64'(ms_to_ws_valid), 64'd0);
      adv();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = v.rdata;
    sample();
    chk("resp_drained", 64'(sb.size()), 64'd0);
    adv();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hCAFE_0000;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    issue(v, 32'h1C00_0000 + 32'(4 * i), 5'(i + 1), 1'b1);
    if (v.mreq) begin
      respond(v);
    end else begin
      sample();
      chk("nomem_latency", 64'(sb.size()), 64'd0);
      adv();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t lw, junk;
    //          op      alu           res   we    mreq  rdata         dly exp
    vecs[0]  = '{3'd0, 32'h0000_1234, 1'b0, 1'b1, 1'b0, 32'h0,        0, 32'h0000_1234};
    vecs[1]  = '{3'd3, 32'h0000_1001, 1'b1, 1'b1, 1'b1, 32'h0080_FF00, 3, 32'hFFFF_FFFF};
    vecs[2]  = '{3'd4, 32'h0000_1001, 1'b1, 1'b1, 1'b1, 32'h0080_FF00, 3, 32'h0000_00FF};
    vecs[3]  = '{3'd1, 32'h0000_2002, 1'b1, 1'b1, 1'b1, 32'h8001_7FFF, 0, 32'hFFFF_8001};
    vecs[4]  = '{3'd2, 32'h0000_2002, 1'b1, 1'b1, 1'b1, 32'h8001_7FFF, 0, 32'h0000_8001};
    vecs[5]  = '{3'd0, 32'h0000_2002, 1'b1, 1'b1, 1'b1, 32'h8001_7FFF, 1, 32'h8001_7FFF};
    vecs[6]  = '{3'd3, 32'h0000_3002, 1'b1, 1'b1, 1'b1, 32'h0080_FF00, 2, 32'hFFFF_FF80};
    vecs[7]  = '{3'd4, 32'h0000_3003, 1'b1, 1'b1, 1'b1, 32'hA580_FF00, 1, 32'h0000_00A5};
    vecs[8]  = '{3'd1, 32'h0000_4000, 1'b1, 1'b1, 1'b1, 32'h1234_F00D, 0, 32'hFFFF_F00D};
    vecs[9]  = '{3'd7, 32'h0000_4001, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF};
    vecs[10] = '{3'd0, 32'h5555_AAAA, 1'b0, 1'b0, 1'b1, 32'h0,        2, 32'h5555_AAAA};
    lw   = '{3'd2, 32'h0000_6002, 1'b1, 1'b1, 1'b1, 32'h8001_7FFF, 0, 32'h0000_8001};
    junk = '{3'd0, 32'h0000_7000, 1'b1, 1'b1, 1'b1, 32'h1111_1111, 0, 32'h0};

    resetn = 1'b0; es_to_ms_valid = 1'b0; es_pc = '0; es_rf_collect = '0; es_mem_req = 1'b0;
    es_ld_op = '0; flush = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    ws_allowin = 1'b1;
    adv();
    adv();
    resetn = 1'b1;
    sample();
    chk("rst_valid", 64'(ms_to_ws_valid), 64'd0);
    chk("rst_coll", 64'(ms_rf_collect), 64'd0);
    chk("rst_pc", 64'(ms_pc), 64'd0);
    chk("rst_block", 64'(ms_ld_block), 64'd0);
    chk("rst_allowin", 64'(ms_allowin), 64'd1);
    adv();

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Back-to-back ALU ops: second one accepted while first leaves, no bubble.
    issue(vecs[0], 32'h1C00_0100, 5'd20, 1'b1);
    issue(vecs[0], 32'h1C00_0104, 5'd21, 1'b1);
    sample();
    chk("b2b_no_bubble", 64'(sb.size()), 64'd0);
    adv();

    // WB stalls for 4 cycles around the response: data must come from the buffer.
    issue(lw, 32'h1C00_0200, 5'd9, 1'b1);
    sample();
    adv();
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = lw.rdata;
    sample();
    adv();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("buf_valid_held", 64'(ms_to_ws_valid), 64'd1);
      chk("buf_no_block", 64'(ms_ld_block), 64'd0);
      chk("buf_allowin", 64'(ms_allowin), 64'd0);
      adv();
    end
    ws_allowin = 1'b1;
    sample();
    chk("buf_drained", 64'(sb.size()), 64'd0);
    adv();
    sample();
    chk("buf_once", 64'(ms_to_ws_valid), 64'd0);
    adv();

    // Flush with a pending MEM load and an EX load in flight: two responses discarded.
    issue(junk, 32'h1C00_0300, 5'd3, 1'b0);
    sample();
    adv();
    flush = 1'b1; es_to_ms_valid = 1'b1; es_mem_req = 1'b1;
    sample();
    chk("flush_no_out", 64'(ms_to_ws_valid), 64'd0);
    adv();
    flush = 1'b0; es_to_ms_valid = 1'b0; es_mem_req = 1'b0;
    issue(lw, 32'h1C00_0304, 5'd4, 1'b1);
    for (int k = 0; k < 2; k++) begin
      data_sram_data_ok = 1'b1;
      data_sram_rdata = junk.rdata;
      sample();
      chk("discard_no_out", 64'(ms_to_ws_valid), 64'd0);
      chk("discard_block", 64'(ms_ld_block), 64'd1);
      adv();
      data_sram_data_ok = 1'b0;
      sample();
      adv();
    end
    respond(lw);

    // Response in the flush cycle with nothing pending is consumed, not counted.
    issue(junk, 32'h1C00_0400, 5'd5, 1'b0);
    flush = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = junk.rdata;
    sample();
    chk("flush_resp_no_out", 64'(ms_to_ws_valid), 64'd0);
    adv();
    flush = 1'b0;
    data_sram_data_ok = 1'b0;
    issue(lw, 32'h1C00_0404, 5'd6, 1'b1);
    respond(lw);

    // Reset mid-wait with a discard pending: everything clears, next load completes at once.
    issue(junk, 32'h1C00_0500, 5'd7, 1'b0);
    flush = 1'b1;
    sample();
    adv();
    flush = 1'b0;
    issue(junk, 32'h1C00_0504, 5'd8, 1'b0);
    sample();
    adv();
    resetn = 1'b0;
    sample();
    adv();
    resetn = 1'b1;
    sample();
    chk("mid_rst_valid", 64'(ms_to_ws_valid), 64'd0);
    chk("mid_rst_coll", 64'(ms_rf_collect), 64'd0);
    chk("mid_rst_pc", 64'(ms_pc), 64'd0);
    chk("mid_rst_block", 64'(ms_ld_block), 64'd0);
    chk("mid_rst_allowin", 64'(ms_allowin), 64'd1);
    adv();
    issue(lw, 32'h1C00_0508, 5'd10, 1'b1);
    respond(lw);

    chk("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
